// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_ctrl
//  Description : Data-memory slave for the core's memory stage. Word-organised
//                SRAM with byte-lane writes and a fixed, parameterised number
//                of wait states between request capture and the one-cycle
//                response strobe.
//                Optional macro DMEM_ACCESS_FAULT_EN adds the access_fault
//                output and blocks accesses whose upper address bits are set.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        request,
    input  logic        we_re,
    input  logic [3:0]  mask,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic [31:0] load_data_out,
    output logic        valid
`ifdef DMEM_ACCESS_FAULT_EN
    ,
    output logic        access_fault
`endif
);

    localparam int         c_depth     = 2 ** ADDR_WIDTH;
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_wait   = 2'd1;
    localparam logic [1:0] c_st_resp   = 2'd2;
    // Counter value on the last WAIT cycle; unused when there are no wait states.
    localparam logic [3:0] c_last_cnt  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam bit         c_zero_wait = (WAIT_STATES == 0);

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic                  r_we;
    logic [3:0]            r_mask;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata;
    logic                  r_valid;
    logic [31:0]           r_mem [0:c_depth-1];

    logic                  w_in_idle;
    logic                  w_commit;
    logic                  w_acc_we;
    logic [3:0]            w_acc_mask;
    logic [31:0]           w_acc_addr;
    logic [31:0]           w_acc_wdata;
    logic [ADDR_WIDTH-1:0] w_acc_idx;
    logic                  w_acc_oob;
    logic                  w_mem_wr;
    logic                  w_unused_bits;

    // Select the access fields: with zero wait states the access happens on the
    // capture edge itself, so the live inputs are used instead of the latches.
    always_comb begin
        w_in_idle   = (r_state == c_st_idle);
        w_commit    = (w_in_idle && request && c_zero_wait) ||
                      ((r_state == c_st_wait) && (r_cnt == c_last_cnt));
        w_acc_we    = w_in_idle ? we_re      : r_we;
        w_acc_mask  = w_in_idle ? mask       : r_mask;
        w_acc_addr  = w_in_idle ? address    : r_addr;
        w_acc_wdata = w_in_idle ? store_data : r_wdata;
        w_acc_idx   = w_acc_addr[ADDR_WIDTH+1:2];
`ifdef DMEM_ACCESS_FAULT_EN
        w_acc_oob   = |w_acc_addr[31:ADDR_WIDTH+2];
`else
        w_acc_oob   = 1'b0;
`endif
        w_mem_wr    = w_commit && w_acc_we && !w_acc_oob;
    end

    // Lane alignment is done by the core, so the byte offset is never needed;
    // without the fault check the upper bits simply alias.
`ifdef DMEM_ACCESS_FAULT_EN
    assign w_unused_bits = ^w_acc_addr[1:0];
`else
    assign w_unused_bits = ^{w_acc_addr[31:ADDR_WIDTH+2], w_acc_addr[1:0]};
`endif

    // SRAM array: byte-lane write at the commit edge; contents are never reset,
    // and a reset on the commit edge drops the pending write.
    always_ff @(posedge clk) begin
        if (!rst && w_mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (w_acc_mask[i]) begin
                    r_mem[w_acc_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
                end
            end
        end
    end

`ifdef DMEM_ACCESS_FAULT_EN
    logic r_fault;

    // Fault flag is raised alongside valid for a blocked access only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= w_commit && w_acc_oob;
        end
    end

    assign access_fault = r_fault;
`endif

    // Control FSM: capture request, count wait states, present the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_mask  <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_commit;
            if (w_commit && !w_acc_we) begin
                r_rdata <= w_acc_oob ? 32'd0 : r_mem[w_acc_idx];
            end
            case (r_state)
                c_st_idle: begin
                    if (request) begin
                        r_we    <= we_re;
                        r_mask  <= mask;
                        r_addr  <= address;
                        r_wdata <= store_data;
                        r_cnt   <= 4'd0;
                        r_state <= c_zero_wait ? c_st_resp : c_st_wait;
                    end
                end
                c_st_wait: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == c_last_cnt) begin
                        r_state <= c_st_resp;
                    end
                end
                c_st_resp: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign load_data_out = r_rdata;
    assign valid         = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_ctrl
//  Description : Directed self-checking bench for data_mem_ctrl. Two instances
//                share the clock and reset: one with one wait state, one with
//                none. A reference memory model and a response scoreboard
//                produce every expected value.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

    typedef struct packed {
        logic        is_read;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic        we_re = 1'b0;
    logic [3:0]  mask = 4'd0;
    logic [31:0] address = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic [31:0] load0;
    logic [31:0] load1;
    logic        valid0;
    logic        valid1;
    logic        fault0;
    logic        fault1;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb_q[$];
    logic [31:0] mdl [0:1][0:1023];
    logic [31:0] last_rd [0:1];

    always #5 clk = ~clk;

    data_mem_ctrl #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut0 (
        .clk           (clk),
        .rst           (rst),
        .request       (req0),
        .we_re         (we_re),
        .mask          (mask),
        .address       (address),
        .store_data    (store_data),
        .load_data_out (load0),
        .valid         (valid0)
`ifdef DMEM_ACCESS_FAULT_EN
        ,
        .access_fault  (fault0)
`endif
    );

    data_mem_ctrl #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_dut1 (
        .clk           (clk),
        .rst           (rst),
        .request       (req1),
        .we_re         (we_re),
        .mask          (mask),
        .address       (address),
        .store_data    (store_data),
        .load_data_out (load1),
        .valid         (valid1)
`ifdef DMEM_ACCESS_FAULT_EN
        ,
        .access_fault  (fault1)
`endif
    );

`ifndef DMEM_ACCESS_FAULT_EN
    assign fault0 = 1'b0;
    assign fault1 = 1'b0;
`endif

    function automatic logic vld(input bit d0);
        return d0 ? valid0 : valid1;
    endfunction

    function automatic logic [31:0] rdat(input bit d0);
        return d0 ? load0 : load1;
    endfunction

    function automatic logic flt(input bit d0);
        return d0 ? fault0 : fault1;
    endfunction

    function automatic bit oob(input logic [31:0] a);
`ifdef DMEM_ACCESS_FAULT_EN
        return |a[31:12];
`else
        return a[31] & 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction on the selected instance, checked end to end.
    task automatic access(input bit d0, input bit w, input logic [3:0] m,
                          input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   lat;
        int   idx;
        idx = int'(a[11:2]);
        @(negedge clk);
        we_re = w; mask = m; address = a; store_data = d;
        if (d0) req0 = 1'b1; else req1 = 1'b1;
        e.is_read = !w;
        e.fault   = oob(a);
        if (w) begin
            e.data = last_rd[d0];
            if (!oob(a)) begin
                for (int i = 0; i < 4; i++)
                    if (m[i]) mdl[d0][idx][8*i +: 8] = d[8*i +: 8];
            end
        end else begin
            e.data = oob(a) ? 32'd0 : mdl[d0][idx];
            last_rd[d0] = e.data;
        end
        sb_q.push_back(e);
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        lat = 1;
        while (!vld(d0) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("valid_seen", {31'd0, vld(d0)}, 32'd1);
        check("latency", 32'(lat), d0 ? 32'd1 : 32'd2);
        if (vld(d0) && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.is_read ? "read_data" : "data_held_on_write", rdat(d0), e.data);
            check("access_fault", {31'd0, flt(d0)}, {31'd0, e.fault});
        end
        @(negedge clk);
        check("valid_width", {31'd0, vld(d0)}, 32'd0);
        check("fault_width", {31'd0, flt(d0)}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        exp_t e;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;

        // Power-on reset.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_valid1", {31'd0, valid1}, 32'd0);
        check("reset_load1", load1, 32'd0);
        check("reset_valid0", {31'd0, valid0}, 32'd0);
        check("reset_load0", load0, 32'd0);
        check("reset_fault1", {31'd0, fault1}, 32'd0);

        // Reset in the middle of a write's wait state.
        access(0, 1'b1, 4'hF, 32'h10, 32'h0BADF00D);
        @(negedge clk);
        we_re = 1'b1; mask = 4'hF; address = 32'h10; store_data = 32'hDEADBEEF;
        req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        rst  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("post_reset_valid", {31'd0, valid1}, 32'd0);
        check("post_reset_load", load1, 32'd0);
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        access(0, 1'b0, 4'hF, 32'h10, 32'd0);

        // Full write then read back, one wait state.
        access(0, 1'b1, 4'hF, 32'h20, 32'h11223344);
        access(0, 1'b0, 4'hF, 32'h20, 32'd0);

        // Byte merge, then a mask-0000 write that must still respond.
        access(0, 1'b1, 4'b0010, 32'h20, 32'h0000AB00);
        access(0, 1'b0, 4'hF, 32'h22, 32'd0);
        access(0, 1'b1, 4'b0000, 32'h20, 32'hFFFFFFFF);
        access(0, 1'b0, 4'hF, 32'h20, 32'd0);

        // Upper address bits: alias by default, blocked with the fault option.
        access(0, 1'b1, 4'hF, 32'h4, 32'h55AA55AA);
        access(0, 1'b1, 4'hF, 32'h1004, 32'hCAFEF00D);
        access(0, 1'b0, 4'hF, 32'h1004, 32'd0);
        access(0, 1'b0, 4'hF, 32'h4, 32'd0);

        // Zero wait states: back-to-back traffic with request held high.
        access(1, 1'b1, 4'hF, 32'h0, 32'hA5A50F0F);
        access(1, 1'b0, 4'hF, 32'h0, 32'd0);
        @(negedge clk);
        we_re = 1'b0; mask = 4'hF; address = 32'h0; req0 = 1'b1;
        e.is_read = 1'b1; e.data = mdl[1][0]; e.fault = 1'b0;
        repeat (3) sb_q.push_back(e);
        last_rd[1] = e.data;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check("held_req_valid", {31'd0, valid0}, {31'd0, k[0] && (k < 7)});
            if (valid0 && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("held_req_data", load0, e.data);
            end
            if (k == 6) req0 = 1'b0;
        end
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
